// File: rtl/microcode_sequencer_pkg.sv
// rtl/microcode_sequencer_pkg.sv - shared mode encodings, microword layout and sequencer states
package microcode_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_NEXT     = 2'd0,
        MODE_JUMP     = 2'd1,
        MODE_DISPATCH = 2'd2,
        MODE_HALT     = 2'd3
    } mode_t;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_t;

    // Microword layout, LSB first: ctrl, next, mode.
    localparam int CTRL_LSB   = 0;
    localparam int MODE_WIDTH = 2;

    function automatic int uw_width(input int cw_width, input int state_width);
        return cw_width + state_width + MODE_WIDTH;
    endfunction

    function automatic int next_lsb(input int cw_width);
        return CTRL_LSB + cw_width;
    endfunction

    function automatic int mode_lsb(input int cw_width, input int state_width);
        return CTRL_LSB + cw_width + state_width;
    endfunction

endpackage

// File: rtl/microcode_sequencer_store.sv
// rtl/microcode_sequencer_store.sv - microcode RAM and opcode dispatch table, sync write, comb read
module microcode_sequencer_store
    import microcode_sequencer_pkg::*;
#(
    parameter int CW_WIDTH     = 20,
    parameter int STATE_WIDTH  = 6,
    parameter int OPCODE_WIDTH = 4,
    parameter int UW_WIDTH     = uw_width(CW_WIDTH, STATE_WIDTH)
) (
    input  logic                    clock,
    input  logic                    we,
    input  logic                    sel,
    input  logic [STATE_WIDTH-1:0]  addr,
    input  logic [UW_WIDTH-1:0]     data,
    input  logic [STATE_WIDTH-1:0]  rd_addr,
    input  logic [OPCODE_WIDTH-1:0] rd_opcode,
    output logic [UW_WIDTH-1:0]     rd_word,
    output logic                    disp_valid,
    output logic [STATE_WIDTH-1:0]  disp_target
);

    localparam int NUM_STATES = 2 ** STATE_WIDTH;
    localparam int NUM_OPS    = 2 ** OPCODE_WIDTH;

    // Contents survive reset by design; software reprograms after power-up.
    logic [UW_WIDTH-1:0]  ucode [NUM_STATES];
    logic [STATE_WIDTH:0] disp  [NUM_OPS];

    always_ff @(posedge clock) begin
        if (we) begin
            if (sel) begin
                disp[addr[OPCODE_WIDTH-1:0]] <= data[STATE_WIDTH:0];
            end else begin
                ucode[addr] <= data;
            end
        end
    end

    assign rd_word     = ucode[rd_addr];
    assign disp_valid  = disp[rd_opcode][STATE_WIDTH];
    assign disp_target = disp[rd_opcode][STATE_WIDTH-1:0];

endmodule

// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - microcode sequencer: fetch, next-address select, registered control word
module microcode_sequencer
    import microcode_sequencer_pkg::*;
#(
    parameter int CW_WIDTH     = 20,
    parameter int STATE_WIDTH  = 6,
    parameter int OPCODE_WIDTH = 4,
    parameter int START_STATE  = 1
) (
    input  logic                                         clock,
    input  logic                                         reset_n,
    input  logic                                         start,
    input  logic                                         stall,
    input  logic [OPCODE_WIDTH-1:0]                      opcode,
    input  logic                                         prog_we,
    input  logic                                         prog_sel,
    input  logic [STATE_WIDTH-1:0]                       prog_addr,
    input  logic [uw_width(CW_WIDTH, STATE_WIDTH)-1:0]   prog_data,
    output logic [CW_WIDTH-1:0]                          control_out,
    output logic [STATE_WIDTH-1:0]                       state,
    output logic                                         busy,
    output logic                                         illegal_op
);

    localparam int UW_WIDTH = uw_width(CW_WIDTH, STATE_WIDTH);
    localparam int NEXT_LSB = next_lsb(CW_WIDTH);
    localparam int MODE_LSB = mode_lsb(CW_WIDTH, STATE_WIDTH);
    localparam logic [STATE_WIDTH-1:0] LAST_STATE  = '1;
    localparam logic [STATE_WIDTH-1:0] FIRST_STATE = STATE_WIDTH'(START_STATE);

    seq_t                   seq_q;
    logic [UW_WIDTH-1:0]    word;
    logic                   disp_valid;
    logic [STATE_WIDTH-1:0] disp_target;

    logic [CW_WIDTH-1:0]    word_ctrl;
    logic [STATE_WIDTH-1:0] word_next;
    mode_t                  word_mode;

    logic [STATE_WIDTH-1:0] nxt_state;
    logic [CW_WIDTH-1:0]    nxt_ctrl;
    logic                   nxt_halt;
    logic                   nxt_illegal;

    // Tables may only change while idle so a running sequence sees a stable program.
    microcode_sequencer_store #(
        .CW_WIDTH     (CW_WIDTH),
        .STATE_WIDTH  (STATE_WIDTH),
        .OPCODE_WIDTH (OPCODE_WIDTH),
        .UW_WIDTH     (UW_WIDTH)
    ) u_store (
        .clock       (clock),
        .we          (prog_we && (seq_q == SEQ_IDLE)),
        .sel         (prog_sel),
        .addr        (prog_addr),
        .data        (prog_data),
        .rd_addr     (state),
        .rd_opcode   (opcode),
        .rd_word     (word),
        .disp_valid  (disp_valid),
        .disp_target (disp_target)
    );

    assign word_ctrl = word[CTRL_LSB +: CW_WIDTH];
    assign word_next = word[NEXT_LSB +: STATE_WIDTH];
    assign word_mode = mode_t'(word[MODE_LSB +: MODE_WIDTH]);

    always_comb begin
        nxt_state   = state;
        nxt_ctrl    = word_ctrl;
        nxt_halt    = 1'b0;
        nxt_illegal = 1'b0;
        case (word_mode)
            MODE_NEXT: begin
                // Falling off the end of the RAM stops rather than wrapping to 0.
                if (state == LAST_STATE) begin
                    nxt_halt = 1'b1;
                end else begin
                    nxt_state = state + STATE_WIDTH'(1);
                end
            end
            MODE_JUMP: begin
                nxt_state = word_next;
            end
            MODE_DISPATCH: begin
                if (disp_valid) begin
                    nxt_state = disp_target;
                end else begin
                    nxt_ctrl    = '0;
                    nxt_illegal = 1'b1;
                    nxt_halt    = 1'b1;
                end
            end
            MODE_HALT: begin
                nxt_halt = 1'b1;
            end
            default: begin
                nxt_halt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seq_q       <= SEQ_IDLE;
            state       <= '0;
            control_out <= '0;
            illegal_op  <= 1'b0;
        end else begin
            case (seq_q)
                SEQ_IDLE: begin
                    control_out <= '0;
                    illegal_op  <= 1'b0;
                    state       <= '0;
                    if (start) begin
                        seq_q <= SEQ_RUN;
                        state <= FIRST_STATE;
                    end
                end
                SEQ_RUN: begin
                    if (!stall) begin
                        control_out <= nxt_ctrl;
                        illegal_op  <= nxt_illegal;
                        if (nxt_halt) begin
                            seq_q <= SEQ_IDLE;
                            state <= '0;
                        end else begin
                            state <= nxt_state;
                        end
                    end
                end
                default: begin
                    seq_q <= SEQ_IDLE;
                end
            endcase
        end
    end

    assign busy = (seq_q == SEQ_RUN);

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb/tb_microcode_sequencer.sv - scoreboarded random and directed bench for microcode_sequencer
module tb_microcode_sequencer;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        stall;
    logic [3:0]  opcode;
    logic        prog_we;
    logic        prog_sel;
    logic [5:0]  prog_addr;
    logic [27:0] prog_data;
    logic [19:0] control_out;
    logic [5:0]  state;
    logic        busy;
    logic        illegal_op;

    int checks = 0;
    int errors = 0;

    // Expected presented output: {state, control_out, busy, illegal_op}
    logic [27:0] exp_q[$];

    // Reference model: program tables plus architectural sequencer state
    logic [27:0] m_ucode [64];
    logic [6:0]  m_disp  [16];
    logic        m_busy;
    logic [5:0]  m_state;
    logic [19:0] m_ctrl;
    logic        m_ill;

    microcode_sequencer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .stall       (stall),
        .opcode      (opcode),
        .prog_we     (prog_we),
        .prog_sel    (prog_sel),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .control_out (control_out),
        .state       (state),
        .busy        (busy),
        .illegal_op  (illegal_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [27:0] uw(input logic [1:0] m, input logic [5:0] n, input logic [19:0] c);
        return {m, n, c};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // One clock edge of the specified behaviour.
    task automatic model_step(input logic st, input logic sl, input logic [3:0] op,
                              input logic we, input logic sel, input logic [5:0] addr,
                              input logic [27:0] data);
        logic [27:0] w;
        logic        halt;
        if (!m_busy) begin
            if (we) begin
                if (sel) m_disp[addr[3:0]] = data[6:0];
                else     m_ucode[addr]     = data;
            end
            m_ctrl  = '0;
            m_ill   = 1'b0;
            m_state = '0;
            if (st) begin
                m_busy  = 1'b1;
                m_state = 6'd1;
            end
        end else if (!sl) begin
            w      = m_ucode[m_state];
            m_ctrl = w[19:0];
            m_ill  = 1'b0;
            halt   = 1'b0;
            if (w[27:26] == 2'd0) begin
                if (m_state == 6'd63) halt = 1'b1;
                else m_state = m_state + 6'd1;
            end else if (w[27:26] == 2'd1) begin
                m_state = w[25:20];
            end else if (w[27:26] == 2'd2) begin
                if (m_disp[op][6]) begin
                    m_state = m_disp[op][5:0];
                end else begin
                    m_ctrl = '0;
                    m_ill  = 1'b1;
                    halt   = 1'b1;
                end
            end else begin
                halt = 1'b1;
            end
            if (halt) begin
                m_busy  = 1'b0;
                m_state = '0;
            end
        end
        if (m_busy || m_ill || m_ctrl != 0)
            exp_q.push_back({m_state, m_ctrl, m_busy, m_ill});
    endtask

    // Drive one cycle's inputs, let the edge happen, then advance the model.
    task automatic tick(input logic st, input logic sl, input logic [3:0] op,
                        input logic we, input logic sel, input logic [5:0] addr,
                        input logic [27:0] data);
        start = st; stall = sl; opcode = op;
        prog_we = we; prog_sel = sel; prog_addr = addr; prog_data = data;
        @(posedge clock);
        #1;
        model_step(st, sl, op, we, sel, addr, data);
        start = 1'b0; stall = 1'b0; prog_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 6'd0, 28'd0);
    endtask

    task automatic wr_uc(input logic [5:0] a, input logic [27:0] d);
        tick(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, a, d);
    endtask

    task automatic wr_disp(input logic [3:0] o, input logic v, input logic [5:0] t);
        tick(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, {2'b00, o}, {21'd0, v, t});
    endtask

    task automatic run_plain(input logic [3:0] op, input int max_cycles);
        tick(1'b1, 1'b0, op, 1'b0, 1'b0, 6'd0, 28'd0);
        for (int i = 0; i < max_cycles && m_busy; i++)
            tick(1'b0, 1'b0, op, 1'b0, 1'b0, 6'd0, 28'd0);
    endtask

    task automatic check_idle(input string name);
        idle(2);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_state"}, {26'd0, state}, 32'd0);
        check({name, "_ctrl"}, {12'd0, control_out}, 32'd0);
        check({name, "_drain"}, exp_q.size(), 32'd0);
    endtask

    task automatic do_reset(input string name);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check({name, "_rst"}, {4'd0, state, control_out, busy, illegal_op}, 32'd0);
        m_busy = 1'b0; m_state = '0; m_ctrl = '0; m_ill = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    // Monitor: compare whenever the DUT presents activity on its outputs.
    always @(negedge clock) begin
        if (reset_n && (busy || illegal_op || control_out != 0)) begin
            logic [27:0] got;
            logic [27:0] want;
            checks++;
            got = {state, control_out, busy, illegal_op};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h expected none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL output: got state=%0d ctrl=%h busy=%b ill=%b expected state=%0d ctrl=%h busy=%b ill=%b",
                             got[27:22], got[21:2], got[1], got[0],
                             want[27:22], want[21:2], want[1], want[0]);
                end
            end
        end
    end

    initial begin
        logic [27:0] w;
        int          r;
        reset_n = 1'b0; start = 0; stall = 0; opcode = 0;
        prog_we = 0; prog_sel = 0; prog_addr = 0; prog_data = 0;
        m_busy = 0; m_state = 0; m_ctrl = 0; m_ill = 0;
        for (int i = 0; i < 64; i++) m_ucode[i] = 28'd0;
        for (int i = 0; i < 16; i++) m_disp[i] = 7'd0;
        #3;
        check("reset_outputs", {4'd0, state, control_out, busy, illegal_op}, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        // Clear tables so nothing undefined is ever fetched.
        for (int i = 0; i < 64; i++) wr_uc(i[5:0], uw(2'd3, 6'd0, 20'd0));
        for (int i = 0; i < 16; i++) wr_disp(i[3:0], 1'b0, 6'd0);
        check_idle("after_init");

        // Basic NEXT then HALT
        wr_uc(6'd1, uw(2'd0, 6'd0, 20'h21080));
        wr_uc(6'd2, uw(2'd3, 6'd0, 20'h0040E));
        run_plain(4'd0, 10);
        check_idle("basic");

        // Dispatch valid
        wr_uc(6'd1, uw(2'd2, 6'd0, 20'h0));
        wr_disp(4'd3, 1'b1, 6'd7);
        wr_uc(6'd7, uw(2'd3, 6'd0, 20'h00123));
        run_plain(4'd3, 10);
        check_idle("dispatch");

        // Dispatch invalid
        wr_disp(4'd5, 1'b0, 6'd9);
        run_plain(4'd5, 10);
        check_idle("illegal");

        // Stall mid-sequence
        wr_uc(6'd1, uw(2'd0, 6'd0, 20'h11111));
        wr_uc(6'd2, uw(2'd0, 6'd0, 20'h22222));
        wr_uc(6'd3, uw(2'd0, 6'd0, 20'h33333));
        wr_uc(6'd4, uw(2'd3, 6'd0, 20'h44444));
        tick(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 6'd0, 28'd0);
        tick(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 6'd0, 28'd0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 6'd0, 28'd0);
        for (int i = 0; i < 6 && m_busy; i++) tick(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 6'd0, 28'd0);
        check_idle("stall");

        // Reset mid-run, then restart with retained tables
        wr_uc(6'd1, uw(2'd0, 6'd0, 20'h21080));
        wr_uc(6'd2, uw(2'd3, 6'd0, 20'h0040E));
        tick(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 6'd0, 28'd0);
        tick(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 6'd0, 28'd0);
        do_reset("midrun");
        run_plain(4'd0, 10);
        check_idle("restart");

        // Write while busy is dropped; same write while idle takes effect
        tick(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 6'd0, 28'd0);
        tick(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 6'd2, uw(2'd3, 6'd0, 20'hABCDE));
        for (int i = 0; i < 6 && m_busy; i++) tick(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 6'd0, 28'd0);
        check_idle("busy_write");
        wr_uc(6'd2, uw(2'd3, 6'd0, 20'hABCDE));
        run_plain(4'd0, 10);
        check_idle("idle_write");

        // Write and start on the same edge
        tick(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 6'd1, uw(2'd3, 6'd0, 20'h5A5A5));
        for (int i = 0; i < 6 && m_busy; i++) tick(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 6'd0, 28'd0);
        check_idle("write_start");

        // Top-of-RAM NEXT halts instead of wrapping
        wr_uc(6'd1, uw(2'd1, 6'd63, 20'h00001));
        wr_uc(6'd63, uw(2'd0, 6'd0, 20'h7777F));
        run_plain(4'd0, 10);
        check_idle("top_next");

        // Randomized programs with random stalls, opcodes and spurious writes/starts
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 64; i++) begin
                r = $urandom_range(0, 9);
                w = uw((r < 4) ? 2'd0 : (r < 6) ? 2'd1 : (r < 8) ? 2'd2 : 2'd3,
                       6'($urandom_range(0, 63)), 20'($urandom));
                wr_uc(i[5:0], w);
            end
            for (int i = 0; i < 16; i++)
                wr_disp(i[3:0], ($urandom_range(0, 3) != 0), 6'($urandom_range(0, 63)));
            for (int run = 0; run < 3; run++) begin
                tick(1'b1, 1'b0, 4'($urandom), 1'b0, 1'b0, 6'd0, 28'd0);
                for (int k = 0; k < 80 && m_busy; k++)
                    tick(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0), 4'($urandom),
                         ($urandom_range(0, 9) == 0), 1'($urandom), 6'($urandom), 28'($urandom));
                if (m_busy) do_reset("rand_hang");
                check_idle("rand");
            end
        end

        idle(2);
        check("final_drain", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
